rx_fifo: RTL and testbench
==========================

Name: rx_fifo

Overview:
- Receive-direction byte buffer for the UART–JTAG bridge.
- The UART receiver pushes decoded bytes in; the bridge command parser pops them.
- Owns its storage, occupancy accounting, sticky overflow reporting and RTS flow control with watermark hysteresis.
- Counterpart to the transmit-side FIFO.

Parameters:
- DEPTH, 256, number of byte entries; power of two, at least 4.
- ADDR_BITS, $clog2(DEPTH), pointer width.
- HI_WATER, DEPTH-16, occupancy at or above which rts_n is deasserted (high).
- LO_WATER, DEPTH/2, occupancy at or below which rts_n is reasserted (low); must be less than HI_WATER.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  byte strobe from UART receiver.
- wr_data  in  8  received byte.
- full  out  1  occupancy == DEPTH.
- rd_en  in  1  pop request from parser.
- rd_data  out  8  registered output byte.
- rd_valid  out  1  rd_data updated this cycle.
- empty  out  1  occupancy == 0.
- used  out  ADDR_BITS+1  current occupancy, 0..DEPTH.
- rts_n  out  1  flow control to remote; 0 = send allowed.
- overflow  out  1  sticky; a write was dropped.
- ovf_clr  in  1  clears overflow (and drop_cnt).
- drop_cnt  out  8  saturating dropped-byte count (optional feature).

Behaviour:
- Reset, synchronous, active-high: one clk edge with rst=1 sets:
  - pointers 0, used=0, empty=1, full=0;
  - rd_data=0, rd_valid=0;
  - rts_n=0, overflow=0, drop_cnt=0.
  - Storage contents are not reset.
  - Reset mid-operation discards all entries; any rd_en/wr_en in the reset cycle is ignored.
- Write acceptance: accepted = wr_en && (!full || rd_en).
  - On accept: mem[wr_ptr] <= wr_data; wr_ptr increments and wraps modulo DEPTH.
- Read acceptance: accepted = rd_en && !empty.
  - On accept: rd_data <= mem[rd_ptr] at the same edge; rd_valid=1 for that one following cycle; rd_ptr increments and wraps.
  - Otherwise rd_valid=0 and rd_data holds.
  - Read latency is 1 cycle; there is no fall-through.
- Simultaneous read and write:
  - Empty: write accepted, read ignored; used goes 0→1.
  - Full: both accepted; used stays DEPTH; full stays 1.
  - Otherwise: both accepted; used unchanged.
- Occupancy: used changes by +1 (write only), -1 (read only), or 0.
  - empty and full are decoded combinationally from the registered used.
- Overflow: wr_en && full && !rd_en drops the byte.
  - overflow <= 1 next cycle and stays set until ovf_clr.
  - If ovf_clr and a new drop occur in the same cycle, set wins.
- RTS hysteresis: rts_n is registered and updates on the edge after used crosses a threshold.
  - rts_n goes 1 when used >= HI_WATER.
  - rts_n goes 0 when used <= LO_WATER.
  - Between the thresholds, rts_n holds its current value.
- Pointers are ADDR_BITS wide; used is tracked as a separate counter, so there is no pointer MSB trick.

Optional Feature:
- Macro: RX_FIFO_DROP_CNT_EN.
- Defined: drop_cnt increments by 1 on each dropped write.
  - Saturates at 255.
  - Cleared by ovf_clr; increment wins over clear in the same cycle, giving drop_cnt=1.
- Undefined: drop_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Package uart_bridge_pkg holds:
  - BYTE_W=8;
  - default DEPTH=256;
  - typedef byte_t (logic [7:0]);
  - watermark default offsets.
- Sub-module rx_fifo_mem: simple dual-port register/BRAM array.
  - One write port, one registered read port.
  - Parameterised by DEPTH; instantiated once.
- All pointer, count, flag and RTS logic stays in rx_fifo.

Test Plan:
- Reset then write 0x11,0x22,0x33 → used=3, empty=0; three rd_en pulses give rd_data 0x11,0x22,0x33 each with rd_valid one cycle after rd_en; then empty=1.
- Fill 256 bytes (0x00..0xFF) → full=1, used=256; a 257th write with rd_en=0 → overflow=1, drop_cnt=1 (macro on); drain returns 0x00..0xFF in order.
- Full plus simultaneous rd_en and wr_en with 0xAA → used stays 256, rd_data=0x00, and 0xAA is read last after a full drain; overflow stays 0.
- Empty plus simultaneous rd_en and wr_en with 0x5C → rd_valid=0, used=1; next rd_en gives 0x5C.
- Write 240 bytes → rts_n=1 on the cycle after used=240; read down to 129 → rts_n still 1; read to 128 → rts_n=0 next cycle.
- Push 300 extra writes while full (macro on) → drop_cnt saturates at 255; ovf_clr → overflow=0, drop_cnt=0; assert rst mid-stream → used=0, rts_n=0 next cycle.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bridge_pkg
//  Description : Shared types and default sizing for the UART-JTAG bridge
//                byte buffers (byte type, default depth, watermark offsets).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

    localparam int BYTE_W           = 8;
    localparam int RX_DEPTH_DEFAULT = 256;

    // HI_WATER sits this many entries below DEPTH; LO_WATER is DEPTH divided by this.
    localparam int HI_WATER_OFFSET  = 16;
    localparam int LO_WATER_DIV     = 2;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage : uart_bridge_pkg
`default_nettype wire

// File: rtl/rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fifo_if
//  Description : Write/read/status bundle between the UART receiver, the
//                receive FIFO and the bridge command parser.
//                master = producer/consumer side, slave = FIFO side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_fifo_if
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH_DEFAULT
);
    localparam int ADDR_BITS = $clog2(DEPTH);

    logic               wr_en;
    byte_t              wr_data;
    logic               full;
    logic               rd_en;
    byte_t              rd_data;
    logic               rd_valid;
    logic               empty;
    logic [ADDR_BITS:0] used;
    logic               rts_n;
    logic               overflow;
    logic               ovf_clr;
    logic [7:0]         drop_cnt;

    modport master (
        output wr_en, wr_data, rd_en, ovf_clr,
        input  full, rd_data, rd_valid, empty, used, rts_n, overflow, drop_cnt
    );

    modport slave (
        input  wr_en, wr_data, rd_en, ovf_clr,
        output full, rd_data, rd_valid, empty, used, rts_n, overflow, drop_cnt
    );

endinterface : rx_fifo_if
`default_nettype wire

// File: rtl/rx_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fifo_mem
//  Description : Simple dual-port byte array: one write port, one registered
//                read port. The array itself is never reset; only the read
//                output register clears on rst.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_fifo_mem
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH     = RX_DEPTH_DEFAULT,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 wr_en,
    input  wire logic [ADDR_BITS-1:0] wr_addr,
    input  wire byte_t                wr_data,
    input  wire logic                 rd_en,
    input  wire logic [ADDR_BITS-1:0] rd_addr,
    output byte_t                     rd_data
);

    byte_t r_mem [DEPTH];

    // Write port: store the byte at wr_addr.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-address write in the same cycle returns the old byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule : rx_fifo_mem
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fifo
//  Description : Receive-direction byte FIFO for the UART-JTAG bridge.
//                Occupancy counter, full/empty, sticky overflow and RTS flow
//                control with HI/LO watermark hysteresis. Read latency 1.
//                Optional feature macro: RX_FIFO_DROP_CNT_EN
//                  (saturating dropped-byte counter on drop_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_fifo
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH     = RX_DEPTH_DEFAULT,
    parameter int ADDR_BITS = $clog2(DEPTH),
    parameter int HI_WATER  = DEPTH - HI_WATER_OFFSET,
    parameter int LO_WATER  = DEPTH / LO_WATER_DIV
) (
    input  wire logic clk,
    input  wire logic rst,
    rx_fifo_if.slave  bus
);

    localparam logic [ADDR_BITS:0]   c_depth    = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   c_hi_water = (ADDR_BITS+1)'(HI_WATER);
    localparam logic [ADDR_BITS:0]   c_lo_water = (ADDR_BITS+1)'(LO_WATER);
    localparam logic [ADDR_BITS-1:0] c_ptr_one  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   c_cnt_one  = (ADDR_BITS+1)'(1);

    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_used;
    logic                 r_rd_valid;
    logic                 r_rts_n;
    logic                 r_overflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_drop;
    byte_t w_rd_data;

    assign w_full   = (r_used == c_depth);
    assign w_empty  = (r_used == '0);
    // A write into a full FIFO is still taken when a read frees the slot in the same edge.
    assign w_wr_acc = bus.wr_en && (!w_full || bus.rd_en);
    assign w_rd_acc = bus.rd_en && !w_empty;
    assign w_drop   = bus.wr_en && w_full && !bus.rd_en;

    rx_fifo_mem #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_acc && !rst),
        .wr_addr (r_wr_ptr),
        .wr_data (bus.wr_data),
        .rd_en   (w_rd_acc && !rst),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // Pointers, occupancy and read-valid strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_used     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_used <= r_used + c_cnt_one;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_used <= r_used - c_cnt_one;
            end
        end
    end

    // RTS hysteresis from registered occupancy: deassert at HI, reassert at LO, hold between.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rts_n <= 1'b0;
        end else if (r_used >= c_hi_water) begin
            r_rts_n <= 1'b1;
        end else if (r_used <= c_lo_water) begin
            r_rts_n <= 1'b0;
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef RX_FIFO_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating drop counter; drop with clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && bus.ovf_clr) begin
            r_drop_cnt <= 8'd1;
        end else if (w_drop) begin
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (bus.ovf_clr) begin
            r_drop_cnt <= '0;
        end
    end

    assign bus.drop_cnt = r_drop_cnt;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.used     = r_used;
    assign bus.rd_data  = w_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rts_n    = r_rts_n;
    assign bus.overflow = r_overflow;

endmodule : rx_fifo
`default_nettype wire

// File: tb/tb_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_fifo
//  Description : Self-checking bench for rx_fifo. A queue-based reference
//                model predicts status each cycle; popped bytes go to a
//                scoreboard that a separate monitor checks on rd_valid.
//                Honours RX_FIFO_DROP_CNT_EN for drop_cnt expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_fifo;
    import uart_bridge_pkg::*;

    localparam int DEPTH = 256;
    localparam int HI    = DEPTH - 16;
    localparam int LO    = DEPTH / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_q[$];
    int exp_q[$];
    bit m_rts;
    bit m_ovf;
    bit m_valid;
    int m_drop;
    int m_rd_data;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest predicted pop.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) check("rd_valid_unexpected", int'(bus.rd_valid), 0);
            else                   check("rd_data_order", int'(bus.rd_data), exp_q.pop_front());
        end
    end

    // One clock of stimulus: drive, advance the model, then compare status.
    task automatic step(input bit wr, input int d, input bit rd,
                        input bit clr = 1'b0, input bit rs = 1'b0);
        int n;
        bit drop;
        @(negedge clk);
        bus.wr_en   = wr;
        bus.wr_data = 8'(d);
        bus.rd_en   = rd;
        bus.ovf_clr = clr;
        rst         = rs;
        if (rs) begin
            m_q.delete();
            m_rts = 0; m_ovf = 0; m_drop = 0; m_rd_data = 0; m_valid = 0;
        end else begin
            n       = m_q.size();
            m_valid = rd && (n > 0);
            drop    = wr && (n == DEPTH) && !rd;
            if (n >= HI)      m_rts = 1;
            else if (n <= LO) m_rts = 0;
            if (drop)     m_ovf = 1;
            else if (clr) m_ovf = 0;
`ifdef RX_FIFO_DROP_CNT_EN
            if (drop && clr) m_drop = 1;
            else if (drop)   m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else if (clr)    m_drop = 0;
`endif
            if (m_valid) begin
                m_rd_data = m_q.pop_front();
                exp_q.push_back(m_rd_data);
            end
            if (wr && (n < DEPTH || rd)) m_q.push_back(d & 255);
        end
        @(posedge clk);
        #1;
        check("used",     int'(bus.used),     m_q.size());
        check("empty",    int'(bus.empty),    int'(m_q.size() == 0));
        check("full",     int'(bus.full),     int'(m_q.size() == DEPTH));
        check("rts_n",    int'(bus.rts_n),    int'(m_rts));
        check("overflow", int'(bus.overflow), int'(m_ovf));
        check("drop_cnt", int'(bus.drop_cnt), m_drop);
        check("rd_valid", int'(bus.rd_valid), int'(m_valid));
        check("rd_data",  int'(bus.rd_data),  m_rd_data);
    endtask

    task automatic write_n(input int count, input int base);
        for (int i = 0; i < count; i++) step(1'b1, base + i, 1'b0);
    endtask

    task automatic read_n(input int count);
        for (int i = 0; i < count; i++) step(1'b0, 0, 1'b1);
    endtask

    initial begin
        int wp, rp;
        bus.wr_en = 0; bus.wr_data = '0; bus.rd_en = 0; bus.ovf_clr = 0;

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0);

        // Basic ordering and latency
        step(1, 'h11, 0); step(1, 'h22, 0); step(1, 'h33, 0);
        read_n(3);
        step(0, 0, 0);

        // Fill, overflow, drain
        write_n(DEPTH, 0);
        step(1, 'hEE, 0);
        read_n(DEPTH);
        step(0, 0, 0, 1);

        // Full with simultaneous read and write
        write_n(DEPTH, 0);
        step(1, 'hAA, 1);
        read_n(DEPTH + 1);

        // Empty with simultaneous read and write
        step(1, 'h5C, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Watermark hysteresis
        write_n(HI, 0);
        step(0, 0, 0);
        read_n(HI - (LO + 1));
        step(0, 0, 0);
        read_n(1);
        step(0, 0, 0);
        step(0, 0, 0);
        read_n(LO);

        // Drop counter saturation, clear, then reset mid-stream
        write_n(DEPTH, 7);
        write_n(300, 0);
        step(1, 'h01, 0, 1);
        step(0, 0, 0, 1);
        step(1, 'h42, 1);
        step(1, 'h43, 1, 0, 1);
        step(0, 0, 0);
        step(1, 'h44, 0);
        read_n(2);

        // Randomised traffic with varying pressure
        for (int c = 0; c < 12; c++) begin
            wp = $urandom_range(10, 95);
            rp = $urandom_range(10, 95);
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(0, 99) < wp, $urandom_range(0, 255),
                     $urandom_range(0, 99) < rp,
                     $urandom_range(0, 49) == 0, $urandom_range(0, 799) == 0);
            end
        end

        read_n(DEPTH + 1);
        step(0, 0, 0);
        step(0, 0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rx_fifo
`default_nettype wire
